// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Shares a byte-wide data memory between two requesters (port 0: core
//   load/store unit, port 1: loader/debug). A round-robin arbiter grants one
//   request at a time. Each byte/half/word request is split into little-endian
//   single-byte memory cycles. Loads are reassembled with sign or zero
//   extension.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   reqN_valid        request pending on port N (held until reqN_ready)
//   reqN_we           1 = store, 0 = load
//   reqN_addr         byte address of the lowest byte (wraps modulo 2^AW)
//   reqN_size         00 byte, 01 half, 10 word, 11 illegal
//   reqN_uns          zero-extend load result when 1
//   reqN_wdata        store data, byte k goes to addr+k
//   reqN_ready        one-cycle completion pulse for port N
//   resp_rdata        load result, valid while a ready is high
//   resp_err          illegal-size flag, valid while a ready is high
//   mem_addr/re/we    byte memory address and strobes
//   mem_wdata         byte to write
//   mem_rdata         combinational read data for mem_addr
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// ACCESS | one memory byte per cycle, count selects the byte lane
// DONE   | ready pulse to the granted port with the assembled result
module dmem_access_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [1:0]    req0_size,
  input  logic          req0_uns,
  input  logic [31:0]   req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [1:0]    req1_size,
  input  logic          req1_uns,
  input  logic [31:0]   req1_wdata,
  output logic          req1_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state;
  logic          gnt;
  logic          rr;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   asm_q;
  logic [1:0]    count;

  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [1:0]    sel_size;
  logic          sel_uns;
  logic [31:0]   sel_wdata;
  logic [1:0]    last;
  logic          acc;
  logic          done;
  logic [4:0]    lane;

  // On contention the port that did not win last time gets the grant; rr
  // resets to 1 so port 0 wins the first contest.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~rr;
    else if (req1_valid)          sel = 1'b1;
  end

  assign sel_we    = sel ? req1_we    : req0_we;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_size  = sel ? req1_size  : req0_size;
  assign sel_uns   = sel ? req1_uns   : req0_uns;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;

  assign last = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign lane = {count, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr      <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
      count   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt     <= sel;
            if (req0_valid && req1_valid) rr <= sel;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            size_q  <= sel_size;
            uns_q   <= sel_uns;
            wdata_q <= sel_wdata;
            asm_q   <= '0;
            count   <= 2'd0;
            if (sel_size == 2'b11) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) asm_q[lane +: 8] <= mem_rdata;
          count <= count + 2'd1;
          if (count == last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign acc  = (state == ACCESS);
  assign done = (state == DONE);

  assign mem_addr  = acc ? addr_q + AW'(count) : '0;
  assign mem_re    = acc & ~we_q;
  assign mem_we    = acc & we_q;
  assign mem_wdata = (acc && we_q) ? wdata_q[lane +: 8] : 8'h00;

  assign req0_ready = done & ~gnt;
  assign req1_ready = done & gnt;
  assign resp_err   = done & err_q;

  always_comb begin
    resp_rdata = '0;
    if (done && !we_q && !err_q) begin
      case (size_q)
        2'b00:   resp_rdata = {{24{~uns_q & asm_q[7]}}, asm_q[7:0]};
        2'b01:   resp_rdata = {{16{~uns_q & asm_q[15]}}, asm_q[15:0]};
        default: resp_rdata = asm_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_we, req0_uns, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [1:0]    req0_size;
  logic [31:0]   req0_wdata;
  logic          req1_valid, req1_we, req1_uns, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [1:0]    req1_size;
  logic [31:0]   req1_wdata;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [7:0]    mem_wdata, mem_rdata;

  logic [7:0] mem [1024] = '{default: 8'h00};
  int acc_cnt = 0;
  int rdy_cnt = 0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_size(req0_size), .req0_uns(req0_uns), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_size(req1_size), .req1_uns(req1_uns), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re || mem_we) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
    chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
    if (req0_ready || req1_ready) rdy_cnt <= rdy_cnt + 1;
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic do_req(input logic port, input logic we, input logic [9:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        output logic rport, output logic [31:0] rdata, output logic err,
                        output int lat, output int nacc);
    int a0;
    if (port) begin
      req1_we = we; req1_addr = addr; req1_size = size; req1_uns = uns;
      req1_wdata = wdata; req1_valid = 1'b1;
    end else begin
      req0_we = we; req0_addr = addr; req0_size = size; req0_uns = uns;
      req0_wdata = wdata; req0_valid = 1'b1;
    end
    a0 = acc_cnt;
    lat = 1;
    rport = 1'bx; rdata = 'x; err = 1'bx;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (req0_ready || req1_ready) begin
        rport = req1_ready;
        rdata = resp_rdata;
        err = resp_err;
        break;
      end
      if (lat > 40) begin
        chk("ready_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    nacc = acc_cnt - a0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic        rport, err;
  logic [31:0] rdata;
  int          lat, nacc, exp_acc;
  int          order[6];
  int          ngr, cyc, r0;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 6};
    vecs[1]  = '{1'b0, 1'b0, 10'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 6};
    vecs[2]  = '{1'b0, 1'b0, 10'h013, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b0, 10'h013, 2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0, 3};
    vecs[4]  = '{1'b0, 1'b0, 10'h012, 2'b01, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0, 4};
    vecs[5]  = '{1'b1, 1'b0, 10'h010, 2'b01, 1'b1, 32'h0,        32'h0000BEEF, 1'b0, 4};
    vecs[6]  = '{1'b1, 1'b1, 10'h3FE, 2'b10, 1'b0, 32'h11223344, 32'h00000000, 1'b0, 6};
    vecs[7]  = '{1'b0, 1'b0, 10'h3FE, 2'b10, 1'b0, 32'h0,        32'h11223344, 1'b0, 6};
    vecs[8]  = '{1'b1, 1'b1, 10'h050, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2};
    vecs[9]  = '{1'b1, 1'b0, 10'h3FF, 2'b00, 1'b0, 32'h0,        32'h00000033, 1'b0, 3};
    vecs[10] = '{1'b0, 1'b1, 10'h020, 2'b01, 1'b0, 32'h1234A5C3, 32'h00000000, 1'b0, 4};
    vecs[11] = '{1'b1, 1'b0, 10'h020, 2'b01, 1'b0, 32'h0,        32'hFFFFA5C3, 1'b0, 4};
    vecs[12] = '{1'b0, 1'b0, 10'h020, 2'b10, 1'b0, 32'h0,        32'h0000A5C3, 1'b0, 6};

    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_size = 0; req0_uns = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_size = 0; req1_uns = 0; req1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mem_re_we", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns,
             vecs[i].wdata, rport, rdata, err, lat, nacc);
      exp_acc = (vecs[i].size == 2'b11) ? 0 : (1 << vecs[i].size);
      chk($sformatf("v%0d_port", i), 32'(rport), 32'(vecs[i].port));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_mem_cycles", i), 32'(nacc), 32'(exp_acc));
    end

    chk("mem_010", 32'(mem[10'h010]), 32'hEF);
    chk("mem_011", 32'(mem[10'h011]), 32'hBE);
    chk("mem_012", 32'(mem[10'h012]), 32'hAD);
    chk("mem_013", 32'(mem[10'h013]), 32'hDE);
    chk("mem_3FE", 32'(mem[10'h3FE]), 32'h44);
    chk("mem_3FF", 32'(mem[10'h3FF]), 32'h33);
    chk("mem_000", 32'(mem[10'h000]), 32'h22);
    chk("mem_001", 32'(mem[10'h001]), 32'h11);
    chk("mem_050_untouched", 32'(mem[10'h050]), 32'h00);
    chk("mem_022_untouched", 32'(mem[10'h022]), 32'h00);

    // Contest from reset: port 0 wins first, then grants alternate.
    do_reset();
    req0_we = 0; req0_addr = 10'h010; req0_size = 2'b10; req0_uns = 0;
    req1_we = 0; req1_addr = 10'h020; req1_size = 2'b10; req1_uns = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ngr = 0; cyc = 0;
    while (ngr < 6 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (req0_ready) begin
        order[ngr] = 0; ngr++;
        chk("contest_rdata0", resp_rdata, 32'hDEADBEEF);
      end else if (req1_ready) begin
        order[ngr] = 1; ngr++;
        chk("contest_rdata1", resp_rdata, 32'h0000A5C3);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("contest_grants", 32'(ngr), 32'd6);
    for (int k = 0; k < ngr; k++)
      chk($sformatf("contest_order%0d", k), 32'(order[k]), 32'(k % 2));
    @(posedge clk); #1;

    // Reset during the third byte of a word store.
    req0_we = 1; req0_addr = 10'h040; req0_size = 2'b10; req0_uns = 0;
    req0_wdata = 32'h87654321; req0_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_we", 32'(mem_we), 32'd1);
    chk("abort_pre_addr", 32'(mem_addr), 32'h042);
    rst = 1'b1;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("abort_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    r0 = rdy_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_ready", 32'(rdy_cnt - r0), 32'd0);
    chk("abort_mem_040", 32'(mem[10'h040]), 32'h21);
    chk("abort_mem_041", 32'(mem[10'h041]), 32'h43);
    chk("abort_mem_042", 32'(mem[10'h042]), 32'h00);

    do_req(1'b0, 1'b1, 10'h040, 2'b10, 1'b0, 32'h87654321, rport, rdata, err, lat, nacc);
    chk("reissue_port", 32'(rport), 32'd0);
    chk("reissue_latency", 32'(lat), 32'd6);
    chk("reissue_err", 32'(err), 32'd0);
    do_req(1'b1, 1'b0, 10'h040, 2'b10, 1'b0, 32'h0, rport, rdata, err, lat, nacc);
    chk("reissue_readback", rdata, 32'h87654321);
    chk("reissue_readback_port", 32'(rport), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences and shares the byte-wide data memory between two requesters: port 0 (core load/store unit) and port 1 (loader/debug).
- Round-robin arbitration picks one requester per transaction.
- Each byte/half/word request becomes a little-endian series of single-byte memory cycles.
- Load results are assembled with sign or zero extension.
- Sits between the MEM stage / loader and the data memory array.

Parameters:
- AW, 10, byte-address width; addresses wrap modulo 2^AW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  port 0 request pending
- req0_we  in  1  1 = store, 0 = load
- req0_addr  in  AW  byte address of the lowest byte
- req0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req0_uns  in  1  zero-extend loads when 1
- req0_wdata  in  32  store data; byte k is written to addr+k
- req0_ready  out  1  one-cycle completion pulse for port 0
- req1_valid, req1_we, req1_addr, req1_size, req1_uns, req1_wdata, req1_ready: same as port 0, for port 1
- resp_rdata  out  32  load result, valid while any readyN = 1
- resp_err  out  1  illegal size, valid while any readyN = 1
- mem_addr  out  AW  byte address to memory
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe; memory writes on the clk rising edge
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  combinational read data for mem_addr

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE.
  - req0_ready = req1_ready = 0; resp_rdata = 0; resp_err = 0.
  - mem_re = mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - byte counter = 0; rr pointer = 1 (port 0 wins the first contest).
- Requester rules:
  - Once valid is asserted, the requester holds valid and all request fields stable until its ready pulse.
  - valid may drop the cycle after ready.
  - Fields are latched at grant, so later changes are ignored.
- States:
  - IDLE:
    - If exactly one valid is high, grant it.
    - If both are high, grant the port other than the rr pointer, then set the rr pointer to the granted port.
    - Latch we/addr/size/uns/wdata and clear the assembly register.
    - If size = 11, go to DONE with err = 1 and no memory access.
    - Otherwise go to ACCESS with count = 0.
  - ACCESS:
    - Each cycle drives mem_addr = (addr + count) mod 2^AW.
    - Load: mem_re = 1; mem_rdata is captured into assembly byte lane [count].
    - Store: mem_we = 1; mem_wdata = wdata byte [count].
    - count increments each cycle.
    - After byte nbytes-1 (nbytes = 1/2/4 for size 00/01/10), go to DONE.
  - DONE:
    - Assert ready of the granted port for exactly one cycle.
    - resp_err = latched err.
    - resp_rdata is the assembled load result:
      - byte load: bits 7:0, bit 7 replicated (uns = 0) or zeros (uns = 1);
      - half load: bits 15:0, bit 15 replicated or zeros;
      - word load: all 32 bits.
    - For stores and errors, resp_rdata = 0.
    - Next state is IDLE.
- Latency, valid at IDLE to ready:
  - byte: 3 cycles; half: 4; word: 6; illegal size: 2.
  - Back-to-back requests lose one IDLE cycle between transactions.
- No alignment requirement. A word at address 2^AW-2 touches 2^AW-2, 2^AW-1, 0, 1.
- mem_re and mem_we are never both 1, and both are 0 outside ACCESS.
- Only one readyN is high in any cycle.
- A requester never waits longer than one competing transaction.
- Reset mid-transaction:
  - Immediate abort to IDLE; no ready is issued.
  - Bytes already written stay in memory; the requester must reissue.
- Both ports requesting the same address are serialized in grant order; no merging.

Test Plan:
- Reset, then port0 word store addr 0x010, wdata 0xDEADBEEF -> mem_we for 4 cycles writing EF, BE, AD, DE to 0x010..0x013; req0_ready pulses 6 cycles after valid, resp_err = 0.
- Port0 word load 0x010 after the store -> resp_rdata = 0xDEADBEEF. Byte load 0x013 with uns = 0 -> 0xFFFFFFDE; with uns = 1 -> 0x000000DE. Half load 0x012 with uns = 0 -> 0xFFFFDEAD.
- Both valid in the same cycle from reset: port0 load 0x010, port1 load 0x020 -> port0 served first. With both continuously requesting, grants alternate 0, 1, 0, 1; no port is starved.
- Word store 0x11223344 at 0x3FE (AW = 10) -> bytes written at 0x3FE, 0x3FF, 0x000, 0x001. Readback word at 0x3FE = 0x11223344.
- size = 11 on port1 -> no mem_re/mem_we activity; req1_ready pulses 2 cycles after valid with resp_err = 1, resp_rdata = 0.
- rst asserted during the 3rd byte of a word store -> outputs return to reset values immediately. The reissued request completes normally, and bytes 0-1 of the aborted write are observable in memory.
